// File: rtl/gate_model_sequencer.sv
// Exhaustive stimulus sequencer for a combinational gate model with MISR response compaction.
// Optional golden-signature comparator enabled by defining GM_SEQ_COMPARE_EN.
module gate_model_sequencer #(
    parameter int                N_IN       = 10,
    parameter int                N_OUT      = 10,
    parameter int                SETTLE_CYC = 2,
    parameter logic [N_OUT-1:0]  SEED       = 10'h000,
    parameter logic [N_OUT-1:0]  POLY       = 10'h240
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [N_IN-1:0]   last_vec,
    output logic [N_IN-1:0]   dut_in,
    input  logic [N_OUT-1:0]  dut_out,
    output logic              busy,
    output logic              done,
    output logic [N_OUT-1:0]  signature
`ifdef GM_SEQ_COMPARE_EN
   ,input  logic [N_OUT-1:0]  golden,
    output logic              pass
`endif
);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_t;

    localparam logic [7:0] CNT_INIT = 8'(SETTLE_CYC - 1);

    state_t             r_state;
    state_t             w_nextState;
    logic [N_IN-1:0]    r_idx;
    logic [N_IN-1:0]    r_lastVec;
    logic [N_OUT-1:0]   r_sig;
    logic [7:0]         r_cnt;
    logic [N_OUT-1:0]   w_sigNext;
    logic               w_accept;
    logic               w_captureEn;
    logic               w_abortHit;

    assign w_sigNext = {r_sig[N_OUT-2:0], ^(r_sig & POLY)} ^ dut_out;
    assign dut_in    = r_idx;
    assign signature = r_sig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_captureEn = 1'b0;
        w_abortHit  = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    w_accept    = 1'b1;
                    w_nextState = SETTLE;
                end
            end
            SETTLE: begin
                busy = 1'b1;
                if (abort) begin
                    w_abortHit  = 1'b1;
                    w_nextState = IDLE;
                end else if (r_cnt == 8'd0) begin
                    w_nextState = CAPTURE;
                end
            end
            CAPTURE: begin
                busy = 1'b1;
                if (abort) begin
                    w_abortHit  = 1'b1;
                    w_nextState = IDLE;
                end else begin
                    w_captureEn = 1'b1;
                    w_nextState = (r_idx == r_lastVec) ? DONE : SETTLE;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // The index only advances when the last vector has not been reached, so it cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_lastVec <= '0;
            r_sig     <= SEED;
            r_cnt     <= 8'd0;
        end else begin
            if (w_accept) begin
                r_idx     <= '0;
                r_lastVec <= last_vec;
                r_sig     <= SEED;
                r_cnt     <= CNT_INIT;
            end else if (r_state == SETTLE && !abort && r_cnt != 8'd0) begin
                r_cnt <= r_cnt - 8'd1;
            end else if (w_captureEn) begin
                r_sig <= w_sigNext;
                if (r_idx != r_lastVec) begin
                    r_idx <= r_idx + N_IN'(1);
                    r_cnt <= CNT_INIT;
                end
            end
        end
    end

`ifdef GM_SEQ_COMPARE_EN
    logic r_pass;

    assign pass = r_pass;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pass <= 1'b0;
        end else if (w_accept || w_abortHit) begin
            r_pass <= 1'b0;
        end else if (w_captureEn && r_idx == r_lastVec) begin
            r_pass <= (w_sigNext == golden);
        end
    end
`endif

endmodule

// File: tb/tb_gate_model_sequencer.sv
// Self-checking bench for gate_model_sequencer: table-driven runs against a random gate-model LUT,
// plus hand-written reset, abort and (with GM_SEQ_COMPARE_EN) golden-compare sequences.
module tb_gate_model_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [9:0] lastVec;
    logic [9:0] dutIn;
    logic [9:0] dutOut;
    logic       busy;
    logic       done;
    logic [9:0] signature;
`ifdef GM_SEQ_COMPARE_EN
    logic [9:0] golden;
    logic       pass;
`endif

    logic [9:0] gateLut [0:1023];
    bit         tieEn;
    logic [9:0] tieVal;

    int checkCount;
    int errorCount;

    typedef struct {
        logic [9:0] lastV;
        bit         useTie;
        logic [9:0] tieV;
        logic [9:0] expSig;
    } vec_t;

    vec_t vecs [9];

    gate_model_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .last_vec  (lastVec),
        .dut_in    (dutIn),
        .dut_out   (dutOut),
        .busy      (busy),
        .done      (done),
        .signature (signature)
`ifdef GM_SEQ_COMPARE_EN
       ,.golden    (golden),
        .pass      (pass)
`endif
    );

    // The gate model is a random lookup table, or a constant when tied off.
    assign dutOut = tieEn ? tieVal : gateLut[dutIn];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Signature a correct run should leave: x^10+x^7+1 shift with response XOR, vector by vector.
    function automatic logic [9:0] misrRef(input int lastV, input bit tieE, input logic [9:0] tieV);
        logic [9:0] s = 10'h000;
        logic       fb;
        for (int v = 0; v <= lastV; v++) begin
            fb = s[9] ^ s[6];
            s  = {s[8:0], fb} ^ (tieE ? tieV : gateLut[v]);
        end
        return s;
    endfunction

    // One full run; cycle 1 is the cycle right after the edge that samples start.
    task automatic applyStimulus(input vec_t v, input string tag);
        int doneCyc;
        int busyCnt;
        int idxErr;
        int limit;
        tieEn   = v.useTie;
        tieVal  = v.tieV;
        lastVec = v.lastV;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        lastVec = 10'($urandom);
        doneCyc = -1;
        busyCnt = 0;
        idxErr  = 0;
        limit   = (int'(v.lastV) + 1) * 3 + 10;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (busy) begin
                busyCnt++;
                if (int'(dutIn) != (c - 1) / 3) idxErr++;
            end
            if (done) begin
                doneCyc = c;
                break;
            end
        end
        checkOutput({tag, "_doneCycle"}, doneCyc, (int'(v.lastV) + 1) * 3 + 1);
        checkOutput({tag, "_busyCycles"}, busyCnt, (int'(v.lastV) + 1) * 3);
        checkOutput({tag, "_dutInSeqErrs"}, idxErr, 0);
        checkOutput({tag, "_signature"}, signature, v.expSig);
        checkOutput({tag, "_dutInHold"}, dutIn, v.lastV);
        @(negedge clk);
        checkOutput({tag, "_donePulseEnds"}, {busy, done}, 2'b00);
        checkOutput({tag, "_sigHeld"}, signature, v.expSig);
    endtask

    initial begin
        vec_t       av;
        logic [9:0] partial;
        int         doneSeen;
        checkCount = 0;
        errorCount = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        lastVec = 10'h000;
        tieEn   = 1'b0;
        tieVal  = 10'h000;
`ifdef GM_SEQ_COMPARE_EN
        golden  = 10'h000;
`endif
        for (int i = 0; i < 1024; i++) gateLut[i] = 10'($urandom);

        vecs[0] = '{10'h3FF, 1'b1, 10'h000, 10'h000};
        vecs[1] = '{10'h000, 1'b1, 10'h001, 10'h001};
        vecs[2] = '{10'h001, 1'b1, 10'h001, 10'h003};
        vecs[3] = '{10'h002, 1'b1, 10'h001, 10'h007};
        vecs[4] = '{10'h003, 1'b0, 10'h000, 10'h000};
        for (int i = 5; i < 8; i++) vecs[i] = '{10'($urandom_range(0, 40)), 1'b0, 10'h000, 10'h000};
        vecs[8] = '{10'h3FF, 1'b0, 10'h000, 10'h000};
        for (int i = 4; i < 9; i++) vecs[i].expSig = misrRef(int'(vecs[i].lastV), 1'b0, 10'h000);

        #1;
        checkOutput("resetOutputs", {dutIn, busy, done, signature}, {10'h000, 1'b0, 1'b0, 10'h000});
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idleAfterReset", {busy, done}, 2'b00);

        for (int i = 0; i < 9; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // Asynchronous reset in the middle of a run, with no clock edge in between.
        tieEn   = 1'b0;
        lastVec = 10'd20;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(negedge clk);
        checkOutput("preResetDutIn", dutIn, 10'd2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midRunReset", {dutIn, busy, done, signature}, {10'h000, 1'b0, 1'b0, 10'h000});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Abort during vector 1, with a start attempt while busy beforehand.
        lastVec = 10'd10;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("startIgnoredBusy", {busy, dutIn}, {1'b1, 10'd1});
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort   = 1'b0;
        partial = misrRef(0, 1'b0, 10'h000);
        checkOutput("abortIdle", {busy, done}, 2'b00);
        checkOutput("abortPartialSig", signature, partial);
        checkOutput("abortDutInHold", dutIn, 10'd1);
        doneSeen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done || busy) doneSeen++;
        end
        checkOutput("abortNoDone", doneSeen, 0);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checkOutput("startAbortIdle", busy, 1'b0);
        checkOutput("startAbortSigHeld", signature, partial);
        av = '{10'd2, 1'b0, 10'h000, 10'h000};
        av.expSig = misrRef(2, 1'b0, 10'h000);
        applyStimulus(av, "afterAbort");

`ifdef GM_SEQ_COMPARE_EN
        golden = 10'h003;
        applyStimulus(vecs[2], "goldenMatch");
        checkOutput("passMatch", pass, 1'b1);
        golden = 10'h002;
        applyStimulus(vecs[2], "goldenMiss");
        checkOutput("passMiss", pass, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
